// File: rtl/icache_dm_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_dm_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH = 32;
  localparam int unsigned ICACHE_LINE_WORDS = 4;
  localparam int unsigned ICACHE_SETS       = 64;

  localparam int unsigned ICACHE_OFF_W = $clog2(ICACHE_LINE_WORDS * 4);
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W = ICACHE_ADDR_WIDTH - ICACHE_OFF_W - ICACHE_IDX_W;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IcIdle,
    IcReq,
    IcFill
  } ic_state_e;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-bus signals of the instruction cache.
interface icache_dm_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Icache_NextPC;
  logic                  Icache_Invalidate;
  logic [31:0]           Icache_Instr;
  logic                  Icache_StallReq;
  logic                  Icache_MemReq;
  logic [ADDR_WIDTH-1:0] Icache_MemAddr;
  logic                  Mem_IcacheGnt;
  logic                  Mem_IcacheValid;
  logic [31:0]           Mem_IcacheData;

  // Cache side.
  modport slave (
    input  Icache_NextPC, Icache_Invalidate, Mem_IcacheGnt, Mem_IcacheValid, Mem_IcacheData,
    output Icache_Instr, Icache_StallReq, Icache_MemReq, Icache_MemAddr
  );

  // Core and memory side.
  modport master (
    output Icache_NextPC, Icache_Invalidate, Mem_IcacheGnt, Mem_IcacheValid, Mem_IcacheData,
    input  Icache_Instr, Icache_StallReq, Icache_MemReq, Icache_MemAddr
  );
endinterface

// File: rtl/icache_refill.sv
// Line refill engine: burst request, beat counting, poison on invalidate, array write strobes.
module icache_refill
  import icache_dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         start_base,
  input  logic                          invalidate,
  input  logic                          mem_gnt,
  input  logic                          mem_valid,
  output logic                          busy,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_beat,
  output logic                          wr_last,
  output logic                          set_valid
);

  localparam int unsigned BeatW = $clog2(LINE_WORDS);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);

  ic_state_e             state_q, state_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  poison_q, poison_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IcIdle;
      beat_q   <= '0;
      poison_q <= 1'b0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      poison_q <= poison_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    poison_d  = poison_q;
    base_d    = base_q;
    mem_req   = 1'b0;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    set_valid = 1'b0;
    unique case (state_q)
      IcIdle: begin
        poison_d = 1'b0;
        if (start) begin
          base_d  = start_base;
          state_d = IcReq;
        end
      end
      IcReq: begin
        mem_req = 1'b1;
        if (invalidate) poison_d = 1'b1;
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = IcFill;
        end
      end
      IcFill: begin
        if (invalidate) poison_d = 1'b1;
        if (mem_valid) begin
          wr_en = 1'b1;
          if (beat_q == LastBeat) begin
            wr_last = 1'b1;
            // An invalidate on the final beat must still leave the line invalid.
            set_valid = !poison_q && !invalidate;
            beat_d    = '0;
            state_d   = IcIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IcIdle;
    endcase
  end

  assign busy     = (state_q != IcIdle);
  assign mem_addr = base_q;
  assign wr_beat  = beat_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with halfword fetch and line-crossing support.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned SETS       = ICACHE_SETS
) (
  input logic       clk,
  input logic       rst_n,
  icache_dm_if.slave bus
);

  localparam int unsigned OffW  = $clog2(LINE_WORDS * 4);
  localparam int unsigned WoffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned LineW = ADDR_WIDTH - OffW;
  localparam int unsigned TagW  = LineW - IdxW;

  logic [TagW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][LINE_WORDS];
  logic [SETS-1:0] valid_q;

  logic                  busy, start, wr_en, wr_last, set_valid, mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr, start_base;
  logic [WoffW-1:0]      wr_beat;
  logic [IdxW-1:0]       wr_idx;
  logic [TagW-1:0]       wr_tag;

  logic [ADDR_WIDTH-1:0] pc;
  logic [LineW-1:0]      line_a, line_b;
  logic [IdxW-1:0]       idx_a, idx_b;
  logic [WoffW-1:0]      woff, woff_nx;
  logic                  need_b, hit_a, hit_b, lookup_hit, stall;
  logic [31:0]           lo_word, hi_word, aligned;
  logic                  unused_bits;

  assign pc      = bus.Icache_NextPC;
  assign line_a  = pc[ADDR_WIDTH-1:OffW];
  // Tag carries naturally when the index wraps from SETS-1 to 0.
  assign line_b  = line_a + LineW'(1);
  assign idx_a   = line_a[IdxW-1:0];
  assign idx_b   = line_b[IdxW-1:0];
  assign woff    = pc[OffW-1:2];
  assign woff_nx = woff + WoffW'(1);
  assign need_b  = pc[1] && (woff == WoffW'(LINE_WORDS - 1));

  assign hit_a      = valid_q[idx_a] && (tag_q[idx_a] == line_a[LineW-1:IdxW]);
  assign hit_b      = valid_q[idx_b] && (tag_q[idx_b] == line_b[LineW-1:IdxW]);
  assign lookup_hit = hit_a && (hit_b || !need_b);

  assign lo_word = data_q[idx_a][woff];
  assign hi_word = need_b ? data_q[idx_b][0] : data_q[idx_a][woff_nx];
  assign aligned = pc[1] ? {hi_word[15:0], lo_word[31:16]} : lo_word;

  assign stall      = busy || !lookup_hit;
  assign start      = !busy && !lookup_hit;
  assign start_base = {(hit_a ? line_b : line_a), {OffW{1'b0}}};

  assign wr_idx = mem_addr[OffW+IdxW-1:OffW];
  assign wr_tag = mem_addr[ADDR_WIDTH-1:OffW+IdxW];

  assign bus.Icache_StallReq = stall;
  assign bus.Icache_Instr    = stall ? INSTR_NOP : aligned;
  assign bus.Icache_MemReq   = mem_req;
  assign bus.Icache_MemAddr  = mem_addr;

  assign unused_bits = ^{pc[0], mem_addr[OffW-1:0]};

  icache_refill #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_base (start_base),
    .invalidate (bus.Icache_Invalidate),
    .mem_gnt    (bus.Mem_IcacheGnt),
    .mem_valid  (bus.Mem_IcacheValid),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .wr_en      (wr_en),
    .wr_beat    (wr_beat),
    .wr_last    (wr_last),
    .set_valid  (set_valid)
  );

  // Tag and data storage is deliberately left unreset; valid bits gate it.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_beat] <= bus.Mem_IcacheData;
    if (wr_last) tag_q[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (bus.Icache_Invalidate) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a line-level reference model.
module tb_icache_dm;
  import icache_dm_pkg::*;

  localparam int unsigned Sets      = 64;
  localparam int unsigned LineWords = 4;
  localparam int unsigned NoLine    = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_dm_if #(.ADDR_WIDTH(32)) bus ();

  icache_dm #(
    .ADDR_WIDTH (32),
    .LINE_WORDS (LineWords),
    .SETS       (Sets)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: which line number each set currently holds; memory is a fixed function.
  int unsigned model_line [Sets];
  logic [31:0] burst_q [$];
  int          beats_done = 0;
  int          last_beat_cyc = 0;
  bit          gnt_en = 1'b0;

  // Responder state.
  bit          r_active = 1'b0;
  bit          r_gnt_acc = 1'b0;
  bit          r_val = 1'b0;
  bit          r_g;
  logic [31:0] r_gnt_addr = '0;
  logic [31:0] r_base = '0;
  int          r_beat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    case (w)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_0193;
      default: return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [31:0] lo, hi;
    lo = mem_word(pc);
    hi = mem_word((pc & ~32'h3) + 32'h4);
    return pc[1] ? {hi[15:0], lo[31:16]} : lo;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < Sets; i++) model_line[i] = NoLine;
  endtask

  // Memory bus: random grant delay, random beat gaps, junk Valid/Data outside bursts.
  initial begin
    bus.Mem_IcacheGnt   = 1'b0;
    bus.Mem_IcacheValid = 1'b0;
    bus.Mem_IcacheData  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        r_active  = 1'b0;
        r_gnt_acc = 1'b0;
        r_val     = 1'b0;
      end else begin
        if (r_active && r_val) begin
          r_beat++;
          beats_done = r_beat;
          if (r_beat == LineWords) begin
            r_active      = 1'b0;
            last_beat_cyc = cyc;
          end
        end
        if (r_gnt_acc) begin
          r_active   = 1'b1;
          r_beat     = 0;
          beats_done = 0;
          r_base     = r_gnt_addr;
          burst_q.push_back(r_base);
        end
      end
      r_g = ($urandom_range(1, 0) == 1) && !r_active && (gnt_en || !bus.Icache_MemReq);
      r_gnt_acc  = r_g && rst_n && bus.Icache_MemReq;
      r_gnt_addr = bus.Icache_MemAddr;
      bus.Mem_IcacheGnt = r_g;
      if (r_active) begin
        r_val = ($urandom_range(3, 0) != 0);
        bus.Mem_IcacheData = mem_word(r_base + 32'(4 * r_beat));
      end else begin
        r_val = ($urandom_range(7, 0) == 0);
        bus.Mem_IcacheData = $urandom;
      end
      if (!rst_n) r_val = 1'b0;
      bus.Mem_IcacheValid = r_val;
    end
  end

  task automatic inv_pulse();
    bus.Icache_Invalidate = 1'b1;
    @(posedge clk);
    #1;
    bus.Icache_Invalidate = 1'b0;
    model_clear();
  endtask

  task automatic wait_stall_drop(input string tag);
    int n;
    n = 0;
    while (bus.Icache_StallReq && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_stall_drop"}, bus.Icache_StallReq, 1'b0);
  endtask

  // Starts and ends at posedge+1.
  task automatic do_fetch(input logic [31:0] pc);
    logic [31:0] exp_q [$];
    int unsigned la, lb;
    bit need_b;
    la     = pc >> 4;
    lb     = la + 1;
    need_b = (pc[3:1] == 3'b111);
    if (model_line[la % Sets] != la) exp_q.push_back(la << 4);
    if (need_b && model_line[lb % Sets] != lb) exp_q.push_back(lb << 4);
    burst_q.delete();
    bus.Icache_NextPC = pc;
    @(negedge clk);
    check_eq($sformatf("stall_first pc=%h", pc), bus.Icache_StallReq, exp_q.size() != 0);
    if (exp_q.size() == 0) begin
      check_eq("hit_no_memreq", bus.Icache_MemReq, 1'b0);
    end else begin
      wait_stall_drop("fetch");
      check_eq("drop_latency", 32'(cyc - last_beat_cyc), 32'd0);
      check_eq($sformatf("n_bursts pc=%h", pc), burst_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
        if (i < burst_q.size()) check_eq("burst_addr", burst_q[i], exp_q[i]);
        model_line[(exp_q[i] >> 4) % Sets] = exp_q[i] >> 4;
      end
    end
    check_eq($sformatf("instr pc=%h", pc), bus.Icache_Instr, ref_instr(pc));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int want);
    int n;
    n = 0;
    while (!(burst_q.size() == 1 && beats_done >= want && beats_done < LineWords) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_sync", beats_done, want);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n                 = 1'b0;
    bus.Icache_NextPC     = '0;
    bus.Icache_Invalidate = 1'b0;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", bus.Icache_StallReq, 1'b1);
    check_eq("rst_instr", bus.Icache_Instr, INSTR_NOP);
    check_eq("rst_memreq", bus.Icache_MemReq, 1'b0);
    check_eq("rst_memaddr", bus.Icache_MemAddr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_stall", bus.Icache_StallReq, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check_eq("t1_memreq", bus.Icache_MemReq, 1'b1);
      check_eq("t1_memaddr", bus.Icache_MemAddr, 32'h0);
    end
    @(posedge clk);
    #1;
    gnt_en = 1'b1;
    do_fetch(32'h0);
    do_fetch(32'h4);

    // Unaligned within the line.
    do_fetch(32'h6);
    @(negedge clk);
    check_eq("t2_const", bus.Icache_Instr, 32'h0113_0010);
    @(posedge clk);
    #1;

    // Line crossing, then both lines missing.
    do_fetch(32'hE);
    inv_pulse();
    do_fetch(32'hE);
    do_fetch(32'h3FE);

    // Conflict on the same index.
    do_fetch(32'h400);
    do_fetch(32'h0);

    // Invalidate mid-fill: line is poisoned, same line refetched.
    inv_pulse();
    burst_q.delete();
    bus.Icache_NextPC = 32'h40;
    wait_beats(2);
    @(posedge clk);
    #1;
    bus.Icache_Invalidate = 1'b1;
    @(posedge clk);
    #1;
    bus.Icache_Invalidate = 1'b0;
    @(negedge clk);
    wait_stall_drop("t5");
    check_eq("t5_n_bursts", burst_q.size(), 32'd2);
    foreach (burst_q[i]) check_eq("t5_addr", burst_q[i], 32'h40);
    check_eq("t5_instr", bus.Icache_Instr, ref_instr(32'h40));
    model_clear();
    model_line[4] = 4;
    @(posedge clk);
    #1;

    // Reset mid-burst.
    burst_q.delete();
    bus.Icache_NextPC = 32'h80;
    wait_beats(2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_memreq", bus.Icache_MemReq, 1'b0);
    check_eq("t6_memaddr", bus.Icache_MemAddr, 32'h0);
    check_eq("t6_stall", bus.Icache_StallReq, 1'b1);
    check_eq("t6_instr", bus.Icache_Instr, INSTR_NOP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    do_fetch(32'h82);
    do_fetch(32'h40);

    // Random fetches over a window that aliases across several tags.
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(11, 0);
      if (r == 0) inv_pulse();
      if (r < 3) pc = ($urandom_range(32'h1FF, 0) << 4) | 32'hE;
      else if (r < 6) pc = {27'd0, model_line[$urandom_range(Sets - 1, 0)][0 +: 1], 4'd0} | 32'h8;
      else pc = $urandom_range(32'h1FFF, 0) & ~32'h1;
      do_fetch(pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
